// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with block refill and perf counters
module instr_cache #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 3,
   parameter int WPB_LOG2 = 2,
   parameter int CNT_W    = 16,
   localparam int TAG_W   = ADDR_W - 2 - WPB_LOG2 - INDEX_W,
   localparam int BLK_W   = 32 << WPB_LOG2,
   localparam int MADDR_W = ADDR_W - 2 - WPB_LOG2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        PC,
   output logic [31:0]        INSTRUCTION,
   output logic               BUSYWAIT,
   output logic               MEM_READ,
   output logic [MADDR_W-1:0] MEM_ADDRESS,
   input  logic [BLK_W-1:0]   MEM_READDATA,
   input  logic               MEM_BUSYWAIT,
   output logic [CNT_W-1:0]   HIT_COUNT,
   output logic [CNT_W-1:0]   MISS_COUNT
);

   localparam int LINES = 1 << INDEX_W;
   localparam int WPB   = 1 << WPB_LOG2;

   typedef enum logic {S_IDLE, S_FETCH} state_t;

   state_t state, state_nxt;

   logic [LINES-1:0]           valid;
   logic [TAG_W-1:0]           tag_mem  [LINES];
   logic [WPB-1:0][31:0]       data_mem [LINES];

   // Block address captured on the miss; the refill uses this, not the live PC
   logic [MADDR_W-1:0]         fetch_addr;
   // High in the first IDLE cycle after a refill (replayed lookup, not a hit)
   logic                       replay;

   logic [TAG_W-1:0]           pc_tag;
   logic [INDEX_W-1:0]         pc_index;
   logic [WPB_LOG2-1:0]        pc_word;
   logic [TAG_W-1:0]           fill_tag;
   logic [INDEX_W-1:0]         fill_index;
   logic                       hit;
   logic                       fill_done;
   logic                       unused_pc_bits;

   assign pc_tag         = PC[ADDR_W-1 -: TAG_W];
   assign pc_index       = PC[2+WPB_LOG2 +: INDEX_W];
   assign pc_word        = PC[2 +: WPB_LOG2];
   assign fill_tag       = fetch_addr[MADDR_W-1 -: TAG_W];
   assign fill_index     = fetch_addr[INDEX_W-1:0];
   assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

   assign hit         = (state == S_IDLE) && valid[pc_index] && (tag_mem[pc_index] == pc_tag);
   assign fill_done   = (state == S_FETCH) && !MEM_BUSYWAIT;
   assign INSTRUCTION = hit ? data_mem[pc_index][pc_word] : 32'h0;

   // Next-state and handshake outputs; reset forces the stall and request low at once
   always_comb begin
      state_nxt   = state;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = '0;
      case (state)
         S_IDLE: begin
            if (!hit) begin
               BUSYWAIT  = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = fetch_addr;
            if (!MEM_BUSYWAIT) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (RESET) begin
         BUSYWAIT    = 1'b0;
         MEM_READ    = 1'b0;
         MEM_ADDRESS = '0;
      end
   end

   // Controller state, valid bits, miss address latch and saturating counters
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= S_IDLE;
         valid      <= '0;
         fetch_addr <= '0;
         replay     <= 1'b0;
         HIT_COUNT  <= '0;
         MISS_COUNT <= '0;
      end else begin
         state  <= state_nxt;
         replay <= fill_done;
         if (state == S_IDLE && !hit) begin
            fetch_addr <= PC[ADDR_W-1:2+WPB_LOG2];
            if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 1'b1;
         end
         if (hit && !replay && HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 1'b1;
         if (fill_done) valid[fill_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; a reset mid-fetch suppresses the write
   always_ff @(posedge CLK) begin
      if (!RESET && fill_done) begin
         data_mem[fill_index] <= MEM_READDATA;
         tag_mem[fill_index]  <= fill_tag;
      end
   end

endmodule
